// File: rtl/fifo_umbral.sv
`default_nettype none
//============================================================================
// Module   : fifo_umbral
// Purpose  : Synchronous FIFO for one virtual-channel queue with
//            programmable almost-full / almost-empty flags. Words are
//            stored and returned untouched; field layout is opaque here.
// Ports    : clk, reset          - rising-edge clock, sync active-high reset
//            wr_enable, data_in  - push request and write word
//            rd_enable           - pop request
//            full_threshold      - almost-full margin below MEM_SIZE
//            empty_threshold     - almost-empty level
//            data_out, valid_out - registered pop data, valid one cycle later
//            fifo_empty/full     - count == 0 / count == MEM_SIZE
//            almost_full/empty   - threshold flags (combinational from count)
//            error               - dropped-write indicator
// Options  : FIFO_ERROR_STICKY_EN - when defined, error latches until reset;
//            otherwise error is a one-cycle pulse after each dropped write.
// Revision : 1.0 - initial release
//============================================================================
module fifo_umbral #(
    parameter int MEM_SIZE  = 8,
    parameter int WORD_SIZE = 12,
    parameter int PTR       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_enable,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 rd_enable,
    input  logic [PTR-1:0]       full_threshold,
    input  logic [PTR-1:0]       empty_threshold,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error
);

    localparam logic [PTR:0] c_mem_size = (PTR+1)'(MEM_SIZE);

    logic [WORD_SIZE-1:0] mem [MEM_SIZE];

    logic [PTR-1:0]       wr_ptr_q,   wr_ptr_d;
    logic [PTR-1:0]       rd_ptr_q,   rd_ptr_d;
    logic [PTR:0]         count_q,    count_d;
    logic [WORD_SIZE-1:0] data_out_q, data_out_d;
    logic                 valid_out_q, valid_out_d;
    logic                 error_q,    error_d;

    logic w_rd_accept;
    logic w_wr_accept;
    logic w_overflow;

    // A read only needs data present; a write at full is still legal when a
    // read frees a slot on the same edge. No bypass: at empty the read loses.
    assign w_rd_accept = rd_enable && (count_q != '0);
    assign w_wr_accept = wr_enable && ((count_q < c_mem_size) || w_rd_accept);
    assign w_overflow  = wr_enable && !w_wr_accept;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;

        if (w_wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_accept) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            data_out_d  = mem[rd_ptr_q];
            valid_out_d = 1'b1;
        end

        case ({w_wr_accept, w_rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

`ifdef FIFO_ERROR_STICKY_EN
        error_d = error_q || w_overflow;
`else
        error_d = w_overflow;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            error_q     <= error_d;
        end
    end

    // Storage is not reset; reset still blocks a concurrent write.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_accept) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    // Thresholds are zero-extended to count width; full_threshold is at most
    // MEM_SIZE-1 so the subtraction stays non-negative.
    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == c_mem_size);
    assign almost_full  = (count_q >= (c_mem_size - {1'b0, full_threshold}));
    assign almost_empty = (count_q <= {1'b0, empty_threshold});

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_umbral.sv
`default_nettype none
//============================================================================
// Module   : tb_fifo_umbral
// Purpose  : Self-checking bench for fifo_umbral. A queue-based reference
//            model predicts accepted pops (pushed to a scoreboard) and the
//            flag levels; a negedge monitor compares the DUT against them.
// Revision : 1.0 - initial release
//============================================================================
module tb_fifo_umbral;

    localparam int MEM_SIZE  = 8;
    localparam int WORD_SIZE = 12;
    localparam int PTR       = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 wr_enable = 1'b0;
    logic [WORD_SIZE-1:0] data_in = '0;
    logic                 rd_enable = 1'b0;
    logic [PTR-1:0]       full_threshold = 3'd2;
    logic [PTR-1:0]       empty_threshold = 3'd1;
    logic [WORD_SIZE-1:0] data_out;
    logic                 valid_out;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 error;

    fifo_umbral #(
        .MEM_SIZE  (MEM_SIZE),
        .WORD_SIZE (WORD_SIZE),
        .PTR       (PTR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_enable       (wr_enable),
        .data_in         (data_in),
        .rd_enable       (rd_enable),
        .full_threshold  (full_threshold),
        .empty_threshold (empty_threshold),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .error           (error)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [WORD_SIZE-1:0] model[$];
    logic [WORD_SIZE-1:0] sb[$];
    logic [WORD_SIZE-1:0] exp_dout  = '0;
    logic                 exp_valid = 1'b0;
    logic                 exp_err   = 1'b0;
    logic                 mon_en    = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [WORD_SIZE-1:0] act,
                         input logic [WORD_SIZE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int c;
            int ft;
            int et;
            c  = model.size();
            ft = int'(full_threshold);
            et = int'(empty_threshold);
            check("fifo_empty",   {11'd0, fifo_empty},   {11'd0, c == 0});
            check("fifo_full",    {11'd0, fifo_full},    {11'd0, c == MEM_SIZE});
            check("almost_full",  {11'd0, almost_full},  {11'd0, c >= MEM_SIZE - ft});
            check("almost_empty", {11'd0, almost_empty}, {11'd0, c <= et});
            check("error",        {11'd0, error},        {11'd0, exp_err});
            check("valid_out",    {11'd0, valid_out},    {11'd0, exp_valid});
            check("data_out_hold", data_out, exp_dout);
            if (valid_out) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_order at %0t: got %h expected no word", $time, data_out);
                end else begin
                    check("pop_order", data_out, sb.pop_front());
                end
            end else if (sb.size() > 0) begin
                void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus; model is advanced at the edge the DUT samples.
    task automatic cycle(input logic w, input logic [WORD_SIZE-1:0] d,
                         input logic r, input logic rst);
        logic rd_ok;
        logic wr_ok;
        logic drop;
        wr_enable = w;
        data_in   = d;
        rd_enable = r;
        reset     = rst;
        @(posedge clk);
        if (rst) begin
            model.delete();
            exp_valid = 1'b0;
            exp_dout  = '0;
            exp_err   = 1'b0;
        end else begin
            rd_ok = r && (model.size() > 0);
            wr_ok = w && ((model.size() < MEM_SIZE) || rd_ok);
            drop  = w && !wr_ok;
            if (rd_ok) begin
                exp_dout = model.pop_front();
                sb.push_back(exp_dout);
            end
            exp_valid = rd_ok;
            if (wr_ok) model.push_back(d);
`ifdef FIFO_ERROR_STICKY_EN
            exp_err = exp_err || drop;
`else
            exp_err = drop;
`endif
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        mon_en = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        idle(2);

        // Fill with 0x001..0x008 then drain in order
        full_threshold = 3'd2;
        for (int i = 1; i <= 8; i++) cycle(1'b1, 12'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        // Overflow: write 0xABC at full
        for (int i = 0; i < 8; i++) cycle(1'b1, 12'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 12'hABC, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Read+write at full, then at empty
        for (int i = 0; i < 8; i++) cycle(1'b1, 12'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 12'h555, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 12'h3C3, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        // Wrap-around rounds with empty_threshold 2
        empty_threshold = 3'd2;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) cycle(1'b1, 12'($urandom), 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        end

        // Reset while writing
        for (int i = 0; i < 4; i++) cycle(1'b1, 12'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 12'h777, 1'b1, 1'b1);
        idle(2);

        // Randomised traffic with live threshold changes and rare resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                full_threshold  = 3'($urandom_range(0, 7));
                empty_threshold = 3'($urandom_range(0, 7));
            end
            cycle(1'($urandom_range(0, 99) < 55), 12'($urandom),
                  1'($urandom_range(0, 99) < 45),
                  1'($urandom_range(0, 199) == 0));
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        idle(2);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
